// File: rtl/seq_divider_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH_N = 5;
  localparam int DEF_WIDTH_D = 3;

  function automatic int cnt_width(input int width_n);
    return $clog2(width_n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the
// divisor through a ripple full-adder chain, keep the difference when no borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic [WIDTH_D:0]   r,
  input  logic               din,
  input  logic [WIDTH_D-1:0] d,
  output logic [WIDTH_D:0]   r_next,
  output logic               qbit
);

  logic [WIDTH_D:0]   s_s;
  logic [WIDTH_D:0]   b_s;
  logic [WIDTH_D:0]   t_s;
  logic [WIDTH_D+1:0] c_s;
  // R never exceeds the divisor, so its top bit is always shifted out.
  logic               unused_msb_s;

  assign unused_msb_s = r[WIDTH_D];
  assign s_s          = {r[WIDTH_D-1:0], din};
  assign b_s          = ~{1'b0, d};
  assign c_s[0]       = 1'b1;

  for (genvar i = 0; i <= WIDTH_D; i++) begin : g_fa
    assign t_s[i]   = s_s[i] ^ b_s[i] ^ c_s[i];
    assign c_s[i+1] = (s_s[i] & b_s[i]) | (c_s[i] & (s_s[i] ^ b_s[i]));
  end

  // Carry-out set means the subtraction did not borrow.
  assign qbit   = c_s[WIDTH_D+1];
  assign r_next = qbit ? t_s : s_s;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_ZERO_EARLY_EXIT_EN: a zero divisor skips the iterations.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int            CW       = cnt_width(WIDTH_N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH_N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t             state_r, next_state_s;
  logic [WIDTH_N-1:0] q_r, q_next_s;
  logic [WIDTH_D:0]   r_r, step_r_s;
  logic [WIDTH_D-1:0] d_r;
  logic [CW-1:0]      cnt_r;
  logic               dbz_r;
  logic               step_q_s;
  logic               zero_exit_s;
  logic               busy_r, done_r, div_by_zero_r;
  logic [WIDTH_N-1:0] quotient_r;
  logic [WIDTH_D-1:0] remainder_r;

`ifdef SEQ_DIVIDER_ZERO_EARLY_EXIT_EN
  assign zero_exit_s = (divisor == {WIDTH_D{1'b0}});
`else
  assign zero_exit_s = 1'b0;
`endif

  div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .r      (r_r),
    .din    (q_r[WIDTH_N-1]),
    .d      (d_r),
    .r_next (step_r_s),
    .qbit   (step_q_s)
  );

  assign q_next_s = {q_r[WIDTH_N-2:0], step_q_s};

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = zero_exit_s ? DONE : RUN;
        else       next_state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_ONE) next_state_s = DONE;
        else                  next_state_s = RUN;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_r           <= {WIDTH_N{1'b0}};
      r_r           <= {(WIDTH_D+1){1'b0}};
      d_r           <= {WIDTH_D{1'b0}};
      cnt_r         <= {CW{1'b0}};
      dbz_r         <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      quotient_r    <= {WIDTH_N{1'b0}};
      remainder_r   <= {WIDTH_D{1'b0}};
      div_by_zero_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            q_r   <= dividend;
            r_r   <= {(WIDTH_D+1){1'b0}};
            d_r   <= divisor;
            cnt_r <= CNT_LOAD;
            dbz_r <= (divisor == {WIDTH_D{1'b0}});
            if (zero_exit_s) begin
              quotient_r    <= {WIDTH_N{1'b1}};
              remainder_r   <= dividend[WIDTH_D-1:0];
              div_by_zero_r <= 1'b1;
            end
          end
        end
        RUN: begin
          q_r   <= q_next_s;
          r_r   <= step_r_s;
          cnt_r <= cnt_r - CNT_ONE;
          // Results are published only as the last iteration retires.
          if (cnt_r == CNT_ONE) begin
            quotient_r    <= q_next_s;
            remainder_r   <= step_r_s[WIDTH_D-1:0];
            div_by_zero_r <= dbz_r;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule
